refr_tick_gen: RTL

- Parametrised multi-channel periodic tick generator; successor to the fixed 75 Hz refresh tick.
- Each channel emits a one-clock strobe every DIV clocks. DIV is loadable at runtime, and new values apply glitch-free at the next period boundary.
- Channels share global enable and resync controls.
- Drives frame-refresh, ball/paddle update and debounce timing in the HDMI breakout design.

---
 rtl/refr_tick_pkg.sv | 17 +
 rtl/refr_tick_chan.sv | 101 ++++++++++
 rtl/refr_tick_gen.sv | 58 +++++
 3 files changed

// File: rtl/refr_tick_pkg.sv
// Shared constants and helpers for the periodic tick generator.
// Divisor presets assume a 125 MHz system clock.
package refr_tick_pkg;

  localparam int CLK_HZ   = 125000000;
  localparam int DIV_60HZ = 2083333;
  localparam int DIV_75HZ = 1666667;
  localparam int DIV_1KHZ = 125000;

  // Divisors of 0 and 1 both mean "tick every enabled cycle".
  function automatic logic [31:0] clamp_div(
    input logic [31:0] value
  );
    return (value == 32'd0) ? 32'd1 : value;
  endfunction

endpackage

// File: rtl/refr_tick_chan.sv
// One tick channel: counter, active/pending divisor, tick register.
// Ports: clk, reset (async high), en, sync, div_wr, div_in[CNT_W],
//   tick, div_pend; with REFR_TICK_GEN_ONESHOT_EN also oneshot, done.
module refr_tick_chan
  import refr_tick_pkg::*;
#(
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = DIV_75HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
`ifdef REFR_TICK_GEN_ONESHOT_EN
  input  logic             oneshot,
  output logic             done,
`endif
  output logic             tick,
  output logic             div_pend
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_v;
  logic             r_tick;
  logic [CNT_W-1:0] w_last;
  logic             w_term;
  logic             w_run;

  // Terminal count is taken from the clamped divisor so 0 behaves as 1.
  assign w_last = CNT_W'(clamp_div(32'(r_div_act)) - 32'd1);
  assign w_term = (r_cnt == w_last);

`ifdef REFR_TICK_GEN_ONESHOT_EN
  logic r_park;
  logic r_done;
  assign w_run = en & ~r_park;
  assign done  = r_done;
`else
  assign w_run = en;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div_act <= CNT_W'(DEFAULT_DIV);
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_tick    <= 1'b0;
`ifdef REFR_TICK_GEN_ONESHOT_EN
      r_park    <= 1'b0;
      r_done    <= 1'b0;
`endif
    end else if (sync) begin
      // Phase align: restart and commit any divisor waiting to apply.
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_pend_v <= 1'b0;
      if (div_wr)
        r_div_act <= div_in;
      else if (r_pend_v)
        r_div_act <= r_pend;
`ifdef REFR_TICK_GEN_ONESHOT_EN
      r_park <= 1'b0;
      r_done <= 1'b0;
`endif
    end else begin
      if (div_wr)
        r_pend <= div_in;
      if (w_run && w_term) begin
        // Period boundary: wrap and switch divisor glitch-free.
        r_cnt    <= '0;
        r_tick   <= 1'b1;
        r_pend_v <= 1'b0;
        if (div_wr)
          r_div_act <= div_in;
        else if (r_pend_v)
          r_div_act <= r_pend;
`ifdef REFR_TICK_GEN_ONESHOT_EN
        if (oneshot) begin
          r_park <= 1'b1;
          r_done <= 1'b1;
        end
`endif
      end else begin
        r_tick <= 1'b0;
        if (w_run)
          r_cnt <= r_cnt + CNT_W'(1);
        if (div_wr)
          r_pend_v <= 1'b1;
      end
    end
  end

  assign tick     = r_tick;
  assign div_pend = r_pend_v;

endmodule

// File: rtl/refr_tick_gen.sv
// Multi-channel periodic tick generator, runtime-loadable divisors.
// Ports: clk, reset (async high), en, sync, div_wr[N_CH],
//   div_in[N_CH*CNT_W], tick[N_CH], div_pend[N_CH].
// Macro REFR_TICK_GEN_ONESHOT_EN adds oneshot[N_CH] in, done[N_CH] out.
module refr_tick_gen
  import refr_tick_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = 21,
  parameter int DEFAULT_DIV = DIV_75HZ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync,
  input  logic [N_CH-1:0]       div_wr,
  input  logic [N_CH*CNT_W-1:0] div_in,
`ifdef REFR_TICK_GEN_ONESHOT_EN
  input  logic [N_CH-1:0]       oneshot,
  output logic [N_CH-1:0]       done,
`endif
  output logic [N_CH-1:0]       tick,
  output logic [N_CH-1:0]       div_pend
);

  if (N_CH < 1 || N_CH > 8) begin : g_bad_nch
    $error("refr_tick_gen: N_CH must be 1..8");
  end

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_w
    $error("refr_tick_gen: CNT_W must be 1..32");
  end

  if (longint'(DEFAULT_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_div
    $error("refr_tick_gen: DEFAULT_DIV does not fit CNT_W");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    refr_tick_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync     (sync),
      .div_wr   (div_wr[i]),
      .div_in   (div_in[i*CNT_W +: CNT_W]),
`ifdef REFR_TICK_GEN_ONESHOT_EN
      .oneshot  (oneshot[i]),
      .done     (done[i]),
`endif
      .tick     (tick[i]),
      .div_pend (div_pend[i])
    );
  end

endmodule
